// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: circular byte buffer fed from a sequential
// fetch stream, presenting a WIN-byte window to the decoder.
module prefetch_queue #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 16,
  parameter int WIN    = 3,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         fetch_req,
  output logic [ADDR_W-1:0]            fetch_addr,
  input  logic                         fetch_gnt,
  input  logic [DATA_W-1:0]            fetch_data,
  input  logic                         flush,
  input  logic [ADDR_W-1:0]            flush_pc,
  output logic [WIN*DATA_W-1:0]        win_data,
  output logic [$clog2(WIN+1)-1:0]     win_avail,
  output logic [ADDR_W-1:0]            win_pc,
  input  logic                         pop,
  input  logic [$clog2(WIN+1)-1:0]     pop_len,
  output logic                         pop_err,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int CW = $clog2(WIN+1);
  localparam int NW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [NW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] win_pc_q, win_pc_d;
  logic              pop_err_q, pop_err_d;

  logic              push;
  logic              pop_ok;
  logic [CW-1:0]     avail;

  always_comb begin
    full      = (count_q == NW'(DEPTH));
    empty     = (count_q == '0);
    fetch_req = !rst && !flush && !full;
    push      = fetch_req && fetch_gnt;
    avail     = (count_q < NW'(WIN)) ? CW'(count_q) : CW'(WIN);
    pop_ok    = pop && (pop_len != '0) && (pop_len <= avail);
  end

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    fetch_addr_d = fetch_addr_q;
    win_pc_d     = win_pc_q;
    pop_err_d    = 1'b0;
    if (flush) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      fetch_addr_d = flush_pc;
      win_pc_d     = flush_pc;
    end else begin
      pop_err_d = pop && !pop_ok;
      if (push) begin
        wr_ptr_d     = wr_ptr_q + 1'b1;
        fetch_addr_d = fetch_addr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PW'(pop_len);
        win_pc_d = win_pc_q + ADDR_W'(pop_len);
      end
      count_d = count_q + NW'(push)
              - (pop_ok ? NW'(pop_len) : NW'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      fetch_addr_q <= RESET_PC;
      win_pc_q     <= RESET_PC;
      pop_err_q    <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      fetch_addr_q <= fetch_addr_d;
      win_pc_q     <= win_pc_d;
      pop_err_q    <= pop_err_d;
    end
  end

  // Storage needs no reset: bytes beyond the count are masked in the window.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= fetch_data;
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < WIN; i++) begin
      if (i < int'(avail)) begin
        win_data[i*DATA_W +: DATA_W] = mem_q[rd_ptr_q + PW'(i)];
      end
    end
  end

  assign fetch_addr = fetch_addr_q;
  assign win_pc     = win_pc_q;
  assign win_avail  = avail;
  assign pop_err    = pop_err_q;
  assign count      = count_q;

endmodule

// File: tb/tb_prefetch_queue.sv
// Randomised scoreboard bench for prefetch_queue against a byte-queue
// reference model.
module tb_prefetch_queue;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_gnt;
  logic [7:0]  fetch_data;
  logic        flush;
  logic [15:0] flush_pc;
  logic [23:0] win_data;
  logic [1:0]  win_avail;
  logic [15:0] win_pc;
  logic        pop;
  logic [1:0]  pop_len;
  logic        pop_err;
  logic [4:0]  count;
  logic        full;
  logic        empty;

  prefetch_queue dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt), .fetch_data(fetch_data),
    .flush(flush), .flush_pc(flush_pc),
    .win_data(win_data), .win_avail(win_avail), .win_pc(win_pc),
    .pop(pop), .pop_len(pop_len), .pop_err(pop_err),
    .count(count), .full(full), .empty(empty)
  );

  typedef struct {
    int          cnt;
    int          avail;
    logic [23:0] data;
    logic [15:0] pc;
    logic [15:0] fa;
    logic        err;
    logic        full;
    logic        empty;
    logic        req;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mq[$];
  logic [15:0] m_pc, m_fa;
  logic        m_err;
  int          checks = 0;
  int          errors = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic int m_avail();
    return (mq.size() < 3) ? mq.size() : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, record expected outputs, advance model.
  task automatic cycle(input bit r, input bit f, input logic [15:0] fpc,
                       input bit g, input bit p, input int len,
                       input bit en);
    exp_t e;
    int   l, a;
    bit   req, legal;
    @(negedge clk);
    l = len & 3;
    rst = r; flush = f; flush_pc = fpc;
    fetch_gnt = g; pop = p; pop_len = 2'(l);
    fetch_data = m_fa[7:0];
    a = m_avail();
    req = !r && !f && (mq.size() < 16);
    e.cnt = mq.size(); e.avail = a; e.data = '0;
    for (int i = 0; i < a; i++) e.data[i*8 +: 8] = mq[i];
    e.pc = m_pc; e.fa = m_fa; e.err = m_err;
    e.full = (mq.size() == 16); e.empty = (mq.size() == 0);
    e.req = req;
    if (en) exp_q.push_back(e);
    if (r) begin
      mq.delete(); m_pc = 16'h0; m_fa = 16'h0; m_err = 0;
    end else if (f) begin
      mq.delete(); m_pc = fpc; m_fa = fpc; m_err = 0;
    end else begin
      legal = p && l >= 1 && l <= a;
      m_err = p && !legal;
      if (legal) begin
        for (int i = 0; i < l; i++) void'(mq.pop_front());
        m_pc = m_pc + 16'(l);
      end
      if (req && g) begin
        mq.push_back(fetch_data);
        m_fa = m_fa + 16'h1;
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("count", 32'(count), 32'(e.cnt));
        chk("win_avail", 32'(win_avail), 32'(e.avail));
        chk("win_data", 32'(win_data), 32'(e.data));
        chk("win_pc", 32'(win_pc), 32'(e.pc));
        chk("fetch_addr", 32'(fetch_addr), 32'(e.fa));
        chk("pop_err", 32'(pop_err), 32'(e.err));
        chk("full", 32'(full), 32'(e.full));
        chk("empty", 32'(empty), 32'(e.empty));
        chk("fetch_req", 32'(fetch_req), 32'(e.req));
      end
    end
  end

  initial begin : stim
    int a;
    rst = 1; flush = 0; flush_pc = 0; fetch_gnt = 0;
    fetch_data = 0; pop = 0; pop_len = 0;
    m_pc = 0; m_fa = 0; m_err = 0;
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 18; i++) cycle(0, 0, 0, 1, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 1, 1);
    cycle(0, 0, 0, 0, 1, 3, 1);
    cycle(0, 0, 0, 0, 1, 2, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(0, 1, 16'hFFF8, 0, 0, 0, 1);
    for (int i = 0; i < 40; i++) begin
      a = m_avail();
      cycle(0, 0, 0, 1, a > 0, a, 1);
    end
    cycle(0, 1, 16'h1234, 1, 1, 2, 1);
    cycle(0, 0, 0, 1, 0, 0, 1);
    cycle(0, 0, 0, 1, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 3, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) cycle(0, 0, 0, 1, 0, 0, 1);
    cycle(1, 0, 0, 1, 1, 1, 1);
    cycle(1, 0, 0, 1, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom % 97) == 0, ($urandom % 31) == 0,
            16'($urandom), ($urandom % 4) != 0,
            ($urandom % 3) == 0, $urandom % 4, 1);
    end
    cycle(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    #4;
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prefetch_queue.md
# prefetch_queue

Parametrised instruction prefetch queue between the memory fetch port and the instruction decoder. It replaces the fixed 16-byte rotation queue with a circular byte buffer of configurable width and depth. It autonomously fetches sequential bytes from a tracked fetch address and presents a multi-byte window at the head, so the decoder can consume a whole 1–3 byte instruction per cycle. A flush redirects the fetch stream to a new PC for branches, jumps and interrupts.

## Interface
- DATA_W, 8, width of one queue entry (instruction byte)
- ADDR_W, 16, width of fetch and PC addresses
- DEPTH, 16, number of queue entries; power of two, ≥ WIN+1
- WIN, 3, number of head bytes presented to the decoder
- RESET_PC, 0, fetch address and head PC after reset
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- fetch_req  out  1  request for the byte at fetch_addr
- fetch_addr  out  ADDR_W  address of the next byte to fetch
- fetch_gnt  in  1  memory accepts the request; fetch_data is valid in the same cycle
- fetch_data  in  DATA_W  returned byte
- flush  in  1  discard the queue contents and restart fetching at flush_pc
- flush_pc  in  ADDR_W  new stream address
- win_data  out  WIN*DATA_W  head bytes; byte i at bits [i*DATA_W +: DATA_W], byte 0 is the head
- win_avail  out  clog2(WIN+1)  number of valid window bytes, min(count, WIN)
- win_pc  out  ADDR_W  address of the head byte
- pop  in  1  consume pop_len bytes from the head
- pop_len  in  clog2(WIN+1)  number of bytes to consume, legal range 1..win_avail
- pop_err  out  1  registered one-cycle pulse when an illegal pop is ignored
- count  out  clog2(DEPTH+1)  number of occupied entries
- full, empty  out  1  count==DEPTH, count==0

## Operation
- Storage: DEPTH×DATA_W array, read pointer rd_ptr and write pointer wr_ptr, both modulo DEPTH, plus a count register.
- fetch_req = !rst && !flush && (count < DEPTH). The request does not consider a pop in the same cycle.
- Push: fetch_req && fetch_gnt writes fetch_data at wr_ptr. It advances wr_ptr by 1 and fetch_addr by 1 (mod 2^ADDR_W).
- Pop: a pop is legal when pop && 1 ≤ pop_len ≤ win_avail. A legal pop advances rd_ptr and win_pc by pop_len, with win_pc wrapping mod 2^ADDR_W.
- Illegal pop (pop_len==0 or pop_len > win_avail): no state change, and pop_err=1 in the next cycle.
- Simultaneous push and pop: count_next = count + push − pop_len. Both take effect in the same edge.
- Window: byte i = mem[(rd_ptr+i) mod DEPTH] for i < win_avail; otherwise the byte is forced to 0. The read wraps across the end of the buffer.
- Flush, which has priority over push and pop:
  - rd_ptr=wr_ptr=0, count=0.
  - fetch_addr=flush_pc, win_pc=flush_pc.
  - A grant or pop arriving in the flush cycle is ignored.
  - pop_err is not raised in the flush cycle.
- Reset values:
  - count=0, empty=1, full=0.
  - fetch_req=0 while rst is high.
  - fetch_addr=win_pc=RESET_PC.
  - win_avail=0, win_data=0, pop_err=0.
- Invariant: win_pc + count == fetch_addr (mod 2^ADDR_W), except while rst is asserted.

## Timing
- Grant to visibility: a byte granted in cycle N appears in the window and count in cycle N+1. There is no bypass from fetch_data to win_data.
- Pop: win_data, win_avail, win_pc and count reflect a pop at edge N in cycle N+1.
- Flush: asserted in cycle N gives empty=1 and fetch_addr=flush_pc in cycle N+1. fetch_req is high again in cycle N+1 if flush is deasserted.
- Fill rate: with fetch_gnt held high, the queue fills one entry per cycle and reaches full after DEPTH cycles. fetch_req drops in the cycle where count==DEPTH.
- Full with a pop: no push occurs in that cycle. Push resumes in the next cycle.
- Reset mid-stream: reset takes effect at the next edge regardless of pop, flush or grant. The queue contents are discarded.
- pop_err is high for exactly one cycle per illegal pop.

## Test plan
- Reset then fill: rst for 2 cycles, then fetch_gnt=1 with fetch_data = address low byte.
  - fetch_addr steps 0,1,2,…; full asserts after 16 cycles and fetch_req drops.
  - win_data = {02,01,00}, win_avail=3, win_pc=0.
- Variable pops: from full, pop 1, then 3, then 2 with no grants.
  - win_pc goes 1, 4, 6; count goes 15, 12, 10.
  - After the pop of 3, win_data = {06,05,04}.
- Wrap-around: with DEPTH=16, keep pushing and popping 3 bytes per cycle for 40 cycles at constant fetch_gnt=1.
  - Window bytes always equal the address low bytes.
  - No byte is lost or duplicated across the rd_ptr/wr_ptr wrap.
  - fetch_addr wraps from FFFF to 0000 correctly when started at flush_pc=FFF8.
- Flush with simultaneous grant and pop: in one cycle assert flush (flush_pc=1234), fetch_gnt and pop (len 2).
  - Next cycle: count=0, win_pc=1234, fetch_addr=1234.
  - The old grant is discarded and pop_err=0.
- Illegal pop: with count=2, pop_len=3 → state unchanged, pop_err=1 for one cycle. pop_len=0 behaves the same way.
- Reset mid-operation: assert rst while count=9 and pop=1 → next cycle count=0, fetch_addr=RESET_PC, fetch_req=0 while rst is high.
